// File: rtl/bus_slave_port_if.sv
// ---------------------------------------------------------------------------
// bus_slave_port_if
// Bundle of the serial slave bus signals shared between the bus master /
// fabric and one bus_slave_port instance.
//
//   B_UTIL    master -> slave  frame active (address, ack, data phases)
//   A_ADD     master -> slave  high during the 16 address cycles
//   B_RW      master -> slave  1 = write, 0 = read (valid on last address bit)
//   B_BUS_IN  master -> slave  serial address / write data, LSB first
//   B_BUS_OUT slave -> master  serial read data, LSB first (wired-OR safe)
//   B_ACK     slave -> master  acknowledge window
//   S_WR_EN   slave -> master  one-cycle pulse when a byte is committed
//   S_ADDR    slave -> master  memory index of the current/last accepted frame
//   S_WDATA   slave -> master  byte committed on S_WR_EN
//   S_BUSY    slave -> master  high from address match until frame end/abort
// ---------------------------------------------------------------------------
interface bus_slave_port_if #(
    parameter int MEM_ADDR_W = 8
);
    logic                  B_UTIL;
    logic                  A_ADD;
    logic                  B_RW;
    logic                  B_BUS_IN;
    logic                  B_BUS_OUT;
    logic                  B_ACK;
    logic                  S_WR_EN;
    logic [MEM_ADDR_W-1:0] S_ADDR;
    logic [7:0]            S_WDATA;
    logic                  S_BUSY;

    modport master (
        output B_UTIL, A_ADD, B_RW, B_BUS_IN,
        input  B_BUS_OUT, B_ACK, S_WR_EN, S_ADDR, S_WDATA, S_BUSY
    );

    modport slave (
        input  B_UTIL, A_ADD, B_RW, B_BUS_IN,
        output B_BUS_OUT, B_ACK, S_WR_EN, S_ADDR, S_WDATA, S_BUSY
    );
endinterface

// File: rtl/bus_slave_port.sv
// ---------------------------------------------------------------------------
// bus_slave_port
// Responder end of the 1-bit serial bus. Decodes a 16-bit LSB-first address,
// acknowledges frames whose select field matches SLAVE_ID, and writes or
// returns one byte per frame from a local byte memory.
//
// Ports:
//   CLK  bus clock, all logic on the rising edge
//   RST  synchronous active-high reset (memory contents are kept)
//   bus  bus_slave_port_if.slave: B_UTIL/A_ADD/B_RW/B_BUS_IN in,
//        B_BUS_OUT/B_ACK/S_WR_EN/S_ADDR/S_WDATA/S_BUSY out (all registered)
//
// Address layout: bits [15:16-ID_W] select the slave, bits [MEM_ADDR_W-1:0]
// index the memory, bits in between are ignored. Requires ID_W >= 2,
// MEM_ADDR_W >= 2 and MEM_ADDR_W <= 16-ID_W.
// ---------------------------------------------------------------------------
module bus_slave_port #(
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] SLAVE_ID   = 4'h1,
    parameter int              MEM_ADDR_W = 8,
    parameter int              ACK_LEN    = 4
) (
    input logic             CLK,
    input logic             RST,
    bus_slave_port_if.slave bus
);
    localparam int CNT_W = (ACK_LEN > 16) ? $clog2(ACK_LEN) : 4;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_LEN - 1);
    localparam logic [CNT_W-1:0] IDX_END   = CNT_W'(MEM_ADDR_W);
    localparam logic [CNT_W-1:0] SEL_FIRST = CNT_W'(16 - ID_W);

    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WDATA, ACK_W, RDATA, SKIP} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;      // address bit / ack cycle / data bit
    logic [MEM_ADDR_W-1:0] idx_q;      // memory index bits, shifted in LSB first
    logic [ID_W-2:0]       sel_q;      // select bits except the final bit 15
    logic                  rw_q;
    logic                  a_add_q;    // previous A_ADD, for rising-edge detect in SKIP
    logic [7:0]            wbyte_q;
    logic [7:0]            wbyte_d;
    logic [7:0]            rbyte_q;
    logic                  bus_out_q;
    logic                  ack_q;
    logic                  wr_en_q;
    logic [MEM_ADDR_W-1:0] s_addr_q;
    logic [7:0]            wdata_q;
    logic                  busy_q;

    logic [7:0]            mem_q [2**MEM_ADDR_W];

    logic                  start;
    logic [ID_W-1:0]       sel_d;
    logic                  sel_match;
    logic                  mem_we;

    assign start     = bus.B_UTIL & bus.A_ADD;
    // Bit 15 arrives on the deciding cycle, so it is combined live with the
    // already captured select bits.
    assign sel_d     = {bus.B_BUS_IN, sel_q};
    assign sel_match = (sel_d == SLAVE_ID);
    assign mem_we    = (state_q == WDATA) && bus.B_UTIL && (cnt_q == BIT_LAST);

    always_comb begin
        wbyte_d                = wbyte_q;
        wbyte_d[cnt_q[2:0]]    = bus.B_BUS_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            rw_q      <= 1'b0;
            a_add_q   <= 1'b0;
            wbyte_q   <= '0;
            rbyte_q   <= '0;
            bus_out_q <= 1'b0;
            ack_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            s_addr_q  <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            a_add_q   <= bus.A_ADD;
            wr_en_q   <= 1'b0;
            bus_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // cnt_q is always 0 here, so this captures address bit 0.
                    if (start) begin
                        idx_q   <= {bus.B_BUS_IN, idx_q[MEM_ADDR_W-1:1]};
                        cnt_q   <= CNT_W'(1);
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (!start) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q < IDX_END)
                            idx_q <= {bus.B_BUS_IN, idx_q[MEM_ADDR_W-1:1]};
                        if (cnt_q >= SEL_FIRST && cnt_q != ADDR_LAST)
                            sel_q <= sel_d[ID_W-1:1];
                        if (cnt_q == ADDR_LAST) begin
                            rw_q  <= bus.B_RW;
                            cnt_q <= '0;
                            if (sel_match) begin
                                state_q  <= ACK_A;
                                ack_q    <= 1'b1;
                                busy_q   <= 1'b1;
                                s_addr_q <= idx_q;
                            end else begin
                                state_q <= SKIP;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ACK_A: begin
                    if (!bus.B_UTIL) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        // Prefetch so the first read bit is ready right after the window.
                        rbyte_q <= mem_q[s_addr_q];
                        if (cnt_q == ACK_LAST) begin
                            ack_q   <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= rw_q ? WDATA : RDATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (!bus.B_UTIL) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        wbyte_q <= wbyte_d;
                        if (cnt_q == BIT_LAST) begin
                            wr_en_q <= 1'b1;
                            wdata_q <= wbyte_d;
                            ack_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ACK_W;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ACK_W: begin
                    if (cnt_q == ACK_LAST) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RDATA: begin
                    // B_UTIL low is a hold: counter frozen, line left at 0.
                    if (bus.B_UTIL) begin
                        bus_out_q <= rbyte_q[cnt_q[2:0]];
                        if (cnt_q == BIT_LAST) begin
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                SKIP: begin
                    // A fresh address phase restarts capture as if from IDLE.
                    if (start && !a_add_q) begin
                        idx_q   <= {bus.B_BUS_IN, idx_q[MEM_ADDR_W-1:1]};
                        cnt_q   <= CNT_W'(1);
                        state_q <= ADDR;
                    end else if (!bus.B_UTIL) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we)
            mem_q[s_addr_q] <= wbyte_d;
    end

    assign bus.B_BUS_OUT = bus_out_q;
    assign bus.B_ACK     = ack_q;
    assign bus.S_WR_EN   = wr_en_q;
    assign bus.S_ADDR    = s_addr_q;
    assign bus.S_WDATA   = wdata_q;
    assign bus.S_BUSY    = busy_q;
endmodule

// File: tb/tb_bus_slave_port.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_port
// Directed bench for bus_slave_port: a table of whole frames with expected
// acknowledge/write/read results, plus hand-written hold, abort and reset
// sequences.
// ---------------------------------------------------------------------------
module tb_bus_slave_port;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_slave_port_if #(.MEM_ADDR_W(8)) bus ();

    bus_slave_port #(
        .ID_W      (4),
        .SLAVE_ID  (4'h1),
        .MEM_ADDR_W(8),
        .ACK_LEN   (4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        acc;    // frame expected to be accepted
        logic [7:0]  rdata;  // expected byte on B_BUS_OUT for reads
    } frame_t;

    frame_t frames [9];
    int     pass_cnt  = 0;
    int     total_cnt = 0;
    int     ack_seen  = 0;
    int     wr_seen   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic u, input logic a, input logic r, input logic d);
        bus.B_UTIL   = u;
        bus.A_ADD    = a;
        bus.B_RW     = r;
        bus.B_BUS_IN = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ack_seen += int'(bus.B_ACK);
        wr_seen  += int'(bus.S_WR_EN);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.B_ACK, bus.B_BUS_OUT, bus.S_WR_EN, bus.S_BUSY, bus.S_ADDR, bus.S_WDATA});
    endfunction

    task automatic send_addr(input logic [15:0] addr, input logic rw);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, rw, addr[i]);
            step();
        end
    endtask

    task automatic ack_phase();
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic run_frame(input frame_t f, input string nm);
        logic [7:0] rd;
        ack_seen = 0;
        wr_seen  = 0;
        send_addr(f.addr, f.rw);
        chk({nm, " ack after addr"}, 32'(bus.B_ACK), 32'(f.acc));
        chk({nm, " busy after addr"}, 32'(bus.S_BUSY), 32'(f.acc));
        if (f.acc) chk({nm, " s_addr"}, 32'(bus.S_ADDR), 32'(f.addr[7:0]));
        ack_phase();
        chk({nm, " ack off after window"}, 32'(bus.B_ACK), 32'd0);
        if (f.rw) begin
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, 1'b0, 1'b0, f.wdata[i]);
                step();
            end
            chk({nm, " wr_en pulse"}, 32'(bus.S_WR_EN), 32'(f.acc));
            if (f.acc) chk({nm, " s_wdata"}, 32'(bus.S_WDATA), 32'(f.wdata));
            for (int j = 0; j < 4; j++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                step();
            end
            chk({nm, " ack cycles"}, 32'(ack_seen), f.acc ? 32'd8 : 32'd0);
            chk({nm, " wr_en cycles"}, 32'(wr_seen), f.acc ? 32'd1 : 32'd0);
        end else begin
            rd = '0;
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                step();
                rd[i] = bus.B_BUS_OUT;
            end
            chk({nm, " read byte"}, 32'(rd), 32'(f.rdata));
            chk({nm, " ack cycles"}, 32'(ack_seen), f.acc ? 32'd4 : 32'd0);
            chk({nm, " wr_en cycles"}, 32'(wr_seen), 32'd0);
        end
        chk({nm, " busy at end"}, 32'(bus.S_BUSY), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk({nm, " bus_out idle"}, 32'(bus.B_BUS_OUT), 32'd0);
    endtask

    initial begin : main
        frame_t     f;
        logic [7:0] rd;
        logic [7:0] wd;
        logic [15:0] a;
        int         bad_hold;

        frames[0] = '{16'h1034, 1'b1, 8'hA5, 1'b1, 8'h00};  // write accepted
        frames[1] = '{16'h1034, 1'b0, 8'h00, 1'b1, 8'hA5};  // read back
        frames[2] = '{16'h2034, 1'b1, 8'hFF, 1'b0, 8'h00};  // other slave
        frames[3] = '{16'h1034, 1'b0, 8'h00, 1'b1, 8'hA5};  // untouched
        frames[4] = '{16'h1010, 1'b1, 8'h5A, 1'b1, 8'h00};
        frames[5] = '{16'h1F10, 1'b0, 8'h00, 1'b1, 8'h5A};  // middle bits ignored
        frames[6] = '{16'h10FF, 1'b1, 8'h01, 1'b1, 8'h00};
        frames[7] = '{16'h10FF, 1'b0, 8'h00, 1'b1, 8'h01};
        frames[8] = '{16'h0034, 1'b0, 8'h00, 1'b0, 8'h00};  // read, wrong select

        // Power-on reset
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset outputs", all_outs(), 32'd0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 9; k++) begin
            run_frame(frames[k], $sformatf("frame%0d", k));
        end

        // Read with a 5-cycle hold after bit 2
        ack_seen = 0;
        send_addr(16'h1034, 1'b0);
        ack_phase();
        rd = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            rd[i] = bus.B_BUS_OUT;
        end
        bad_hold = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            step();
            if (bus.B_BUS_OUT !== 1'b0 || bus.S_BUSY !== 1'b1) bad_hold++;
        end
        chk("hold out0 busy1", 32'(bad_hold), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        rd[3] = bus.B_BUS_OUT;
        chk("hold resume bit3", 32'(bus.B_BUS_OUT), 32'd0);
        for (int i = 4; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            rd[i] = bus.B_BUS_OUT;
        end
        chk("hold read byte", 32'(rd), 32'hA5);
        chk("hold busy end", 32'(bus.S_BUSY), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Write aborted after data bit 4
        ack_seen = 0;
        wr_seen  = 0;
        wd = 8'h3C;
        send_addr(16'h1010, 1'b1);
        ack_phase();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, wd[i]);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("abort busy", 32'(bus.S_BUSY), 32'd0);
        chk("abort no write", 32'(wr_seen), 32'd0);
        step();
        f = '{16'h1010, 1'b0, 8'h00, 1'b1, 8'h5A};
        run_frame(f, "after abort");

        // Reset for 2 cycles in the middle of an address phase
        a = 16'h1034;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, a[i]);
            step();
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset mid-addr outputs", all_outs(), 32'd0);
        rst = 1'b0;
        step();
        f = '{16'h1034, 1'b0, 8'h00, 1'b1, 8'hA5};
        run_frame(f, "after reset addr");

        // Reset in the middle of write data: frame dropped, memory kept
        send_addr(16'h1034, 1'b1);
        ack_phase();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset mid-data outputs", all_outs(), 32'd0);
        rst = 1'b0;
        step();
        run_frame(f, "after reset data");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bus_slave_port.md
Name: bus_slave_port

Overview:
- Responder end of the serial 1-bit bus that the bus master drives.
- Decodes a 16-bit serial address, acknowledges frames aimed at it, and stores or returns one byte per frame from a local byte memory.
- Sits behind the arbiter/bus fabric, one instance per slave. Several instances share the same B_BUS_IN/B_UTIL/A_ADD/B_RW nets.

Parameters:
- ID_W, 4, width of slave select field, taken from address bits [15:16-ID_W].
- SLAVE_ID, 4'h1, value the select field must equal for this slave to respond.
- MEM_ADDR_W, 8, local memory index width, taken from address bits [MEM_ADDR_W-1:0]. Constraint: MEM_ADDR_W <= 16-ID_W. Bits in between are ignored (aliasing).
- ACK_LEN, 4, length in cycles of each acknowledge window.

Ports:
- CLK  in  1  bus clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- B_UTIL  in  1  bus frame active; high on every cycle of an address, ack, write or read phase.
- A_ADD  in  1  high during the 16 address-phase cycles.
- B_RW  in  1  1 = write, 0 = read; sampled on the last address cycle.
- B_BUS_IN  in  1  serial data from the master (address and write data, LSB first).
- B_BUS_OUT  out  1  serial read data to the master, LSB first.
- B_ACK  out  1  acknowledge, high for the whole ack window when accepted.
- S_WR_EN  out  1  one-cycle pulse when a byte is committed to memory.
- S_ADDR  out  MEM_ADDR_W  memory index of the current/last accepted frame.
- S_WDATA  out  8  byte committed on S_WR_EN.
- S_BUSY  out  1  high from address match until the frame ends or aborts.

Behaviour:
- Reset (RST sampled high at a clock edge): state IDLE, all outputs 0, bit counter 0, shift registers 0. Memory contents are not reset.
- Reset asserted mid-frame drops the frame; no memory write occurs.
- All outputs are registered.
- States: IDLE, ADDR, ACK_A, WDATA, ACK_W, RDATA, SKIP.
- IDLE:
  - If A_ADD & B_UTIL: capture B_BUS_IN as addr bit 0, counter=1, go to ADDR.
- ADDR:
  - Each cycle with B_UTIL & A_ADD, shift B_BUS_IN into addr bit [counter].
  - When bit 15 is captured, also latch B_RW.
  - Match (addr[15:16-ID_W]==SLAVE_ID): go to ACK_A, set S_BUSY=1, S_ADDR=addr[MEM_ADDR_W-1:0].
  - No match: go to SKIP.
  - B_UTIL or A_ADD low before bit 15: abort to IDLE.
- ACK_A:
  - B_ACK=1 for exactly ACK_LEN cycles, starting the cycle after bit 15 is sampled.
  - Then go to WDATA if the latched RW is 1, or RDATA if it is 0.
  - B_UTIL low in any ACK_A cycle: abort to IDLE, B_ACK=0.
- WDATA:
  - 8 cycles; cycle i shifts B_BUS_IN into wbyte[i].
  - After bit 7: write mem[S_ADDR]=wbyte, pulse S_WR_EN for 1 cycle, S_WDATA=wbyte, go to ACK_W.
  - B_UTIL low before bit 7: abort, no write.
- ACK_W:
  - B_ACK=1 for ACK_LEN cycles, then IDLE, S_BUSY=0.
- RDATA:
  - The byte mem[S_ADDR] is fetched during ACK_A.
  - On read cycle i with B_UTIL=1, B_BUS_OUT = rbyte[i].
  - Cycles with B_UTIL=0 (master lost grant / HOLD): counter frozen, B_BUS_OUT=0, state unchanged. Transfer resumes at the same bit when B_UTIL returns high, with no timeout.
  - After bit 7 is driven: IDLE, S_BUSY=0, B_BUS_OUT=0.
- SKIP:
  - Outputs stay 0.
  - Return to IDLE on the first cycle with B_UTIL=0.
  - A_ADD rising while in SKIP restarts address capture (treated as IDLE).
- B_BUS_OUT is 0 in every state except RDATA with B_UTIL=1. B_ACK is 0 outside the ack windows. This keeps the shared nets wired-OR safe.
- Simultaneous: a new A_ADD in the same cycle a frame completes is captured as bit 0 of the next frame.

Test Plan:
- Reset: RST=1 for 2 cycles mid-ADDR → all outputs 0, state IDLE; a subsequent frame works normally.
- Write: addr 16'h1034, RW=1, data 8'hA5 → B_ACK high 4 cycles after the address; S_WR_EN pulse with S_ADDR=8'h34, S_WDATA=8'hA5; B_ACK high 4 cycles after the data.
- Read back: addr 16'h1034, RW=0 → B_BUS_OUT sequence 1,0,1,0,0,1,0,1 over 8 cycles; S_BUSY falls afterwards.
- Read with hold: same read, B_UTIL low for 5 cycles after bit 2 → B_BUS_OUT=0 while held, resumes with bit 3 (0), full byte 8'hA5 delivered, no bit lost or repeated.
- Mismatch: addr 16'h2034, write 8'hFF → B_ACK never asserts, no S_WR_EN, mem[8'h34] still 8'hA5.
- Abort: write to 16'h1010, B_UTIL dropped after data bit 4 → no S_WR_EN, mem unchanged, next frame accepted.
